button_event_gen: RTL
=====================

# button_event_gen

Converts a debounced button level into discrete, single-cycle user events: press, short click, long press, auto-repeat and release, plus a held level. It sits directly after the per-button debouncer, running on the same 10 ms system tick. It feeds the alarm-clock control FSM, which uses long press to enter set mode and repeat pulses to step hours and minutes while a button is held.

## Interface
- LONG_TICKS, 100, number of clk cycles from press to long-press event (1 s at 10 ms); legal range 1..2^CNT_W
- REPEAT_TICKS, 20, number of clk cycles between auto-repeat pulses (200 ms); legal range 1..2^CNT_W
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W >= max(LONG_TICKS, REPEAT_TICKS)
- clk  input  1  system tick clock, 10 ms period
- rst_n  input  1  reset, asynchronous, active-low
- btn  input  1  debounced button level, 1 = pressed
- press  output  1  one-cycle pulse on press detection
- click  output  1  one-cycle pulse on release before long-press threshold
- long_press  output  1  one-cycle pulse when hold reaches LONG_TICKS
- repeat  output  1  one-cycle pulse every REPEAT_TICKS while in long hold
- release  output  1  one-cycle pulse on every release (short or long)
- held  output  1  level, 1 while state is PRESSED or LONG

## Operation
- All outputs are registered. Reset value is 0 for every output; state = IDLE; cnt = 0.
- The FSM has 3 states: IDLE, PRESSED and LONG. cnt is CNT_W bits wide.
- In IDLE:
  - btn=1 → PRESSED, press<=1, cnt<=0.
  - Otherwise, stay in IDLE.
- In PRESSED:
  - btn=0 → IDLE, click<=1, release<=1.
  - Else, if cnt==LONG_TICKS-1 → LONG, long_press<=1, cnt<=0.
  - Else cnt<=cnt+1.
- In LONG:
  - btn=0 → IDLE, release<=1.
  - Else, behave as described under Configuration.
- Pulse outputs default to 0 every cycle unless set above. held reflects the next state, registered.
- Simultaneous events: release has priority over threshold.
  - btn=0 at PRESSED terminal count gives click+release and no long_press.
  - btn=0 at LONG terminal count gives release and no repeat.
- Re-press is accepted in the cycle immediately after returning to IDLE; no dead time is imposed.
- Asserting rst_n mid-hold clears everything at once and suppresses pending pulses.
- If btn=1 when reset releases, press fires on the first active edge.
- cnt never wraps: it is cleared at each terminal count and on each state entry.

## Timing
- Edge n samples btn=1 in IDLE → press high in cycle n..n+1. Latency is 1 cycle.
- long_press asserts at edge n+LONG_TICKS, exactly LONG_TICKS cycles after press.
- First repeat asserts REPEAT_TICKS cycles after long_press. Later repeats are spaced REPEAT_TICKS cycles apart.
- Release: btn=0 sampled at edge m → click/release high during cycle m..m+1, and held falls at edge m.
- No two of press, long_press and repeat are ever high in the same cycle. click implies release in the same cycle.
- LONG_TICKS=1: long_press fires 1 cycle after press.

## Configuration
- AUTO_REPEAT_EN defined, in LONG with btn=1:
  - If cnt==REPEAT_TICKS-1 → repeat<=1, cnt<=0.
  - Else cnt<=cnt+1.
- AUTO_REPEAT_EN undefined:
  - repeat is constant 0.
  - cnt holds in LONG.
  - REPEAT_TICKS is unused.
  - All other behaviour is identical.

## Test plan
All scenarios use LONG_TICKS=100, REPEAT_TICKS=20, CNT_W=8, AUTO_REPEAT_EN defined unless stated.
- Short tap: btn high 5 cycles then low → press at cycle 1; click+release 1 cycle after btn falls; long_press and repeat never assert; held high 5 cycles.
- Long hold: btn high 160 cycles → press at t0; long_press at t0+100; repeat at t0+120 and t0+140; no repeat at t0+160; release on fall.
- Boundary race: btn falls on the cycle sampled with cnt==99 → click+release, no long_press, state IDLE.
- Back-to-back: tap, release, btn high again the next cycle → second press pulse exactly 1 cycle after release pulse.
- Reset mid-hold: assert rst_n low at t0+110 during LONG → all outputs 0 immediately. Release reset with btn=1 → press on the first edge, long_press 100 cycles later.
- AUTO_REPEAT_EN undefined: btn high 300 cycles → single long_press at t0+100, repeat stays 0 throughout, release on fall.

Source files
------------

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
//
// Turns a debounced button level into single-cycle user events (press, short
// click, long press, auto-repeat, release) plus a registered "held" level.
// Runs on the 10 ms system tick, directly after the per-button debouncer, and
// feeds the alarm-clock control FSM.
//
// Optional feature macro: AUTO_REPEAT_EN
//   defined   : repeat_o pulses every REPEAT_TICKS cycles while in long hold
//   undefined : repeat_o is constant 0, the hold counter freezes in LONG and
//               REPEAT_TICKS has no effect (default build)
//
// Parameters:
//   LONG_TICKS   cycles from press to long-press event      (1 .. 2**CNT_W)
//   REPEAT_TICKS cycles between auto-repeat pulses          (1 .. 2**CNT_W)
//   CNT_W        hold-counter width
//
// Ports:
//   clk           system tick clock
//   rst_n         asynchronous active-low reset
//   btn_i         debounced button level, 1 = pressed
//   press_o       one-cycle pulse on press detection
//   click_o       one-cycle pulse on release before the long-press threshold
//   long_press_o  one-cycle pulse when the hold reaches LONG_TICKS
//   repeat_o      one-cycle pulse every REPEAT_TICKS while in long hold
//   release_o     one-cycle pulse on every release
//   held_o        level, 1 while the FSM is in PRESSED or LONG
//   dbg_state_o   current FSM state (IDLE=0, PRESSED=1, LONG=2)
//
// btn_i is a plain level with no handshake: it is sampled on every rising
// edge of clk, and every output is a registered function of that sample and
// the current state, so consumers see each pulse for exactly one cycle.
// -----------------------------------------------------------------------------
module button_event_gen #(
  parameter int LONG_TICKS   = 100,
  parameter int REPEAT_TICKS = 20,
  parameter int CNT_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_i,
  output logic       press_o,
  output logic       click_o,
  output logic       long_press_o,
  output logic       repeat_o,
  output logic       release_o,
  output logic       held_o,
  output logic [1:0] dbg_state_o
);

  // Reject tick counts the counter cannot reach.
  if (LONG_TICKS < 1 || LONG_TICKS > (1 << CNT_W) ||
      REPEAT_TICKS < 1 || REPEAT_TICKS > (1 << CNT_W)) begin : g_bad_params
    $error("button_event_gen: tick parameters out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_e;

  // Terminal counts: cnt counts 0..N-1, so the event fires on the Nth cycle.
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`endif

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;

  assign dbg_state_o = state_q;

  // Single registered FSM. Release (btn_i=0) is tested before any terminal
  // count, which gives release priority over long_press/repeat on the same
  // edge. held_o is loaded with "next state is not IDLE".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      press_o      <= 1'b0;
      click_o      <= 1'b0;
      long_press_o <= 1'b0;
      repeat_o     <= 1'b0;
      release_o    <= 1'b0;
      held_o       <= 1'b0;
    end else begin
      press_o      <= 1'b0;
      click_o      <= 1'b0;
      long_press_o <= 1'b0;
      repeat_o     <= 1'b0;
      release_o    <= 1'b0;

      case (state_q)
        IDLE: begin
          if (btn_i) begin
            state_q <= PRESSED;
            press_o <= 1'b1;
            cnt_q   <= '0;
            held_o  <= 1'b1;
          end else begin
            held_o  <= 1'b0;
          end
        end

        PRESSED: begin
          if (!btn_i) begin
            state_q   <= IDLE;
            click_o   <= 1'b1;
            release_o <= 1'b1;
            cnt_q     <= '0;
            held_o    <= 1'b0;
          end else if (cnt_q == LONG_LAST) begin
            state_q      <= LONG;
            long_press_o <= 1'b1;
            cnt_q        <= '0;
            held_o       <= 1'b1;
          end else begin
            cnt_q  <= cnt_q + CNT_W'(1);
            held_o <= 1'b1;
          end
        end

        LONG: begin
          if (!btn_i) begin
            state_q   <= IDLE;
            release_o <= 1'b1;
            cnt_q     <= '0;
            held_o    <= 1'b0;
          end else begin
            held_o <= 1'b1;
`ifdef AUTO_REPEAT_EN
            if (cnt_q == REP_LAST) begin
              repeat_o <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
`else
            // Without auto-repeat the counter simply parks while held long.
            cnt_q <= cnt_q;
`endif
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          held_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
